// File: rtl/exception_pkg.sv
// Shared types and constants for the exception controller.
package exception_pkg;

    // Controller states: idle, presenting an exception, handler running.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // Cause indices as wired by the datapath.
    localparam int CAUSE_OPCODE   = 0;
    localparam int CAUSE_OVERFLOW = 1;
    localparam int CAUSE_DIV0     = 2;

    // Vector address of cause 0.
    localparam int unsigned DEFAULT_VECTOR_BASE = 253;

    // Width of a cause index for a given number of causes (at least one bit).
    function automatic int cause_width(input int num_causes);
        return (num_causes > 1) ? $clog2(num_causes) : 1;
    endfunction

endpackage

// File: rtl/exception_unit_if.sv
// Datapath/control-unit side of the exception controller.
interface exception_unit_if
    import exception_pkg::*;
#(
    parameter int NUM_CAUSES  = 3,
    parameter int ADDR_WIDTH  = 32,
    parameter int CAUSE_WIDTH = cause_width(NUM_CAUSES)
);
    logic [NUM_CAUSES-1:0]  excpt_req;
    logic [ADDR_WIDTH-1:0]  excpt_pc;
    logic                   ctrl_ack;
    logic                   eret;
    logic                   excpt_valid;
    logic [ADDR_WIDTH-1:0]  excpt_vector;
    logic [ADDR_WIDTH-1:0]  epc;
    logic [CAUSE_WIDTH-1:0] cause;
    logic [NUM_CAUSES-1:0]  pending;
    logic                   busy;

    // CPU side: raises requests, acknowledges and returns from handlers.
    modport master (
        output excpt_req, excpt_pc, ctrl_ack, eret,
        input  excpt_valid, excpt_vector, epc, cause, pending, busy
    );

    // Exception controller side.
    modport slave (
        input  excpt_req, excpt_pc, ctrl_ack, eret,
        output excpt_valid, excpt_vector, epc, cause, pending, busy
    );
endinterface

// File: rtl/exception_unit_prio_enc.sv
// Highest-index-wins priority encoder over the pending cause bits.
module prio_enc
    import exception_pkg::*;
#(
    parameter int NUM_CAUSES  = 3,
    parameter int CAUSE_WIDTH = cause_width(NUM_CAUSES)
) (
    input  logic [NUM_CAUSES-1:0]  req,
    output logic [CAUSE_WIDTH-1:0] idx,
    output logic                   any
);

    // Scan upwards so the last (highest) set bit overrides lower ones.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < NUM_CAUSES; i++) begin
            if (req[i]) begin
                idx = CAUSE_WIDTH'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exception_unit.sv
// Exception controller: captures per-cause requests, presents the highest
// cause with its vector/EPC until acknowledged, and replays queued causes
// after eret.
module exception_unit
    import exception_pkg::*;
#(
    parameter int          NUM_CAUSES  = 3,
    parameter int          ADDR_WIDTH  = 32,
    parameter int unsigned VECTOR_BASE = DEFAULT_VECTOR_BASE,
    parameter int          CAUSE_WIDTH = cause_width(NUM_CAUSES)
) (
    input logic             clk,
    input logic             reset,
    exception_unit_if.slave bus
);

    // The highest vector must fit in an address.
    localparam logic [64:0] TOP_VECTOR = 65'(VECTOR_BASE) + 65'(NUM_CAUSES) - 65'd1;
    localparam logic [64:0] ADDR_SPAN  = 65'd1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(VECTOR_BASE);

    if (TOP_VECTOR >= ADDR_SPAN) begin : g_bad_vector_base
        $error("exception_unit: VECTOR_BASE + NUM_CAUSES - 1 does not fit in ADDR_WIDTH");
    end
    if (NUM_CAUSES > (1 << CAUSE_WIDTH)) begin : g_bad_cause_width
        $error("exception_unit: CAUSE_WIDTH too small for NUM_CAUSES");
    end

    state_t                 state_q, state_d;
    logic [NUM_CAUSES-1:0]  pend_q;
    logic [NUM_CAUSES-1:0]  pend_next;
    logic [NUM_CAUSES-1:0]  new_bits;
    logic [ADDR_WIDTH-1:0]  pend_pc_q [NUM_CAUSES];

    logic                   select;      // take the top pending cause this edge
    logic [CAUSE_WIDTH-1:0] sel_idx;
    logic                   sel_any;
    logic [NUM_CAUSES-1:0]  sel_mask;
    logic [ADDR_WIDTH-1:0]  sel_pc;

    logic                   valid_q;
    logic                   busy_q;
    logic [ADDR_WIDTH-1:0]  vector_q;
    logic [ADDR_WIDTH-1:0]  epc_q;
    logic [CAUSE_WIDTH-1:0] cause_q;

    // Requests arriving this edge join the queue before selection.
    assign pend_next = pend_q | bus.excpt_req;
    assign new_bits  = bus.excpt_req & ~pend_q;

    prio_enc #(
        .NUM_CAUSES  (NUM_CAUSES),
        .CAUSE_WIDTH (CAUSE_WIDTH)
    ) u_prio_enc (
        .req (pend_next),
        .idx (sel_idx),
        .any (sel_any)
    );

    // One-hot of the selected cause, and its PC: stored if already queued, else the incoming PC.
    always_comb begin
        sel_mask = '0;
        sel_pc   = bus.excpt_pc;
        for (int i = 0; i < NUM_CAUSES; i++) begin
            if (CAUSE_WIDTH'(i) == sel_idx) begin
                sel_mask[i] = 1'b1;
                if (pend_q[i]) begin
                    sel_pc = pend_pc_q[i];
                end
            end
        end
    end

    // Next-state logic; selection happens from IDLE or on eret in SERVICE.
    always_comb begin
        state_d = state_q;
        select  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_any) begin
                    select  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.ctrl_ack) begin
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (bus.eret) begin
                    if (sel_any) begin
                        select  = 1'b1;
                        state_d = HOLD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pending bits and their first-seen PCs; the selected cause leaves the queue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
            // NOTE: the PC store is reset too, so a reset leaves no stale return address.
            for (int i = 0; i < NUM_CAUSES; i++) begin
                pend_pc_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CAUSES; i++) begin
                if (new_bits[i]) begin
                    pend_pc_q[i] <= bus.excpt_pc;
                end
            end
            pend_q <= select ? (pend_next & ~sel_mask) : pend_next;
        end
    end

    // Presented exception: loaded on selection, held through HOLD and SERVICE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cause_q  <= '0;
            epc_q    <= '0;
            vector_q <= '0;
        end else if (select) begin
            cause_q  <= sel_idx;
            epc_q    <= sel_pc;
            vector_q <= BASE + ADDR_WIDTH'(sel_idx);
        end
    end

    // Status flags registered from the next state so they align with the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= (state_d == HOLD);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign bus.excpt_valid  = valid_q;
    assign bus.busy         = busy_q;
    assign bus.excpt_vector = vector_q;
    assign bus.epc          = epc_q;
    assign bus.cause        = cause_q;
    assign bus.pending      = pend_q;

endmodule

// File: tb/tb_exception_unit.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a cycle-level behavioural model of the exception controller.
module tb_exception_unit;

    localparam int VB = 253;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    exception_unit_if #(.NUM_CAUSES(3), .ADDR_WIDTH(32), .CAUSE_WIDTH(2)) bus ();
    exception_unit_if #(.NUM_CAUSES(5), .ADDR_WIDTH(32), .CAUSE_WIDTH(3)) bus5 ();

    exception_unit #(.NUM_CAUSES(3), .ADDR_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    exception_unit #(.NUM_CAUSES(5), .ADDR_WIDTH(32), .VECTOR_BASE(32'h1000)) dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus5.slave)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_HOLD = 1, M_SERVICE = 2;
    int          m_mode;
    bit          m_pend [3];
    logic [31:0] m_pc   [3];
    int          m_cause;
    logic [31:0] m_epc;
    logic [31:0] m_vec;

    task automatic model_reset();
        m_mode = M_IDLE;
        for (int i = 0; i < 3; i++) begin
            m_pend[i] = 0;
            m_pc[i]   = 0;
        end
        m_cause = 0;
        m_epc   = 0;
        m_vec   = 0;
    endtask

    function automatic int top_cause();
        for (int i = 2; i >= 0; i--) begin
            if (m_pend[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic [2:0] req, input logic [31:0] pc,
                              input logic ack, input logic er);
        int k;
        for (int i = 0; i < 3; i++) begin
            if (req[i] && !m_pend[i]) begin
                m_pend[i] = 1;
                m_pc[i]   = pc;
            end
        end
        k = top_cause();
        if ((m_mode == M_IDLE) || (m_mode == M_SERVICE && er)) begin
            if (k >= 0) begin
                m_cause   = k;
                m_epc     = m_pc[k];
                m_vec     = VB + k;
                m_pend[k] = 0;
                m_mode    = M_HOLD;
            end else begin
                m_mode = M_IDLE;
            end
        end else if (m_mode == M_HOLD && ack) begin
            m_mode = M_SERVICE;
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".valid"},   64'(bus.excpt_valid), 64'(m_mode == M_HOLD));
        check({tag, ".busy"},    64'(bus.busy), 64'(m_mode != M_IDLE));
        check({tag, ".cause"},   64'(bus.cause), 64'(m_cause));
        check({tag, ".epc"},     64'(bus.epc), 64'(m_epc));
        check({tag, ".vector"},  64'(bus.excpt_vector), 64'(m_vec));
        check({tag, ".pending"}, 64'(bus.pending), 64'({m_pend[2], m_pend[1], m_pend[0]}));
    endtask

    // Drive one cycle of inputs, advance the model on the edge, compare after it.
    task automatic step(input string tag, input logic [2:0] req, input logic [31:0] pc,
                        input logic ack, input logic er);
        bus.excpt_req = req;
        bus.excpt_pc  = pc;
        bus.ctrl_ack  = ack;
        bus.eret      = er;
        @(posedge clk);
        model_edge(req, pc, ack, er);
        #1;
        compare_model(tag);
    endtask

    task automatic step5(input logic [4:0] req, input logic [31:0] pc,
                         input logic ack, input logic er);
        bus5.excpt_req = req;
        bus5.excpt_pc  = pc;
        bus5.ctrl_ack  = ack;
        bus5.eret      = er;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.excpt_req  = '0;
        bus.excpt_pc   = '0;
        bus.ctrl_ack   = 1'b0;
        bus.eret       = 1'b0;
        bus5.excpt_req = '0;
        bus5.excpt_pc  = '0;
        bus5.ctrl_ack  = 1'b0;
        bus5.eret      = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        compare_model("reset");
        reset = 1'b1;

        // Single cause
        step("single", 3'b010, 32'h40, 0, 0);
        check("single.valid", 64'(bus.excpt_valid), 64'd1);
        check("single.cause", 64'(bus.cause), 64'd1);
        check("single.vector", 64'(bus.excpt_vector), 64'd254);
        check("single.epc", 64'(bus.epc), 64'h40);
        step("single_ack", 3'b000, 32'h0, 1, 0);
        check("single_ack.valid", 64'(bus.excpt_valid), 64'd0);
        check("single_ack.busy", 64'(bus.busy), 64'd1);
        step("single_eret", 3'b000, 32'h0, 0, 1);
        check("single_eret.busy", 64'(bus.busy), 64'd0);

        // Simultaneous causes replay in priority order
        step("simul", 3'b111, 32'h80, 0, 0);
        check("simul.cause", 64'(bus.cause), 64'd2);
        check("simul.vector", 64'(bus.excpt_vector), 64'd255);
        check("simul.pending", 64'(bus.pending), 64'b011);
        step("simul_ack1", 3'b000, 32'h0, 1, 0);
        step("simul_eret1", 3'b000, 32'h0, 0, 1);
        check("simul2.cause", 64'(bus.cause), 64'd1);
        check("simul2.vector", 64'(bus.excpt_vector), 64'd254);
        check("simul2.epc", 64'(bus.epc), 64'h80);
        step("simul_ack2", 3'b000, 32'h0, 1, 0);
        step("simul_eret2", 3'b000, 32'h0, 0, 1);
        check("simul3.cause", 64'(bus.cause), 64'd0);
        check("simul3.vector", 64'(bus.excpt_vector), 64'd253);
        check("simul3.epc", 64'(bus.epc), 64'h80);
        step("simul_ack3", 3'b000, 32'h0, 1, 0);
        step("simul_eret3", 3'b000, 32'h0, 0, 1);
        check("simul_done.busy", 64'(bus.busy), 64'd0);

        // Nested request during SERVICE
        step("nest", 3'b001, 32'h200, 0, 0);
        step("nest_ack", 3'b000, 32'h0, 1, 0);
        step("nest_req", 3'b100, 32'h100, 0, 0);
        check("nest.pending", 64'(bus.pending), 64'b100);
        check("nest.valid", 64'(bus.excpt_valid), 64'd0);
        step("nest_eret", 3'b000, 32'h0, 0, 1);
        check("nest_eret.valid", 64'(bus.excpt_valid), 64'd1);
        check("nest_eret.cause", 64'(bus.cause), 64'd2);
        check("nest_eret.epc", 64'(bus.epc), 64'h100);
        step("nest_ack2", 3'b000, 32'h0, 1, 0);
        step("nest_eret2", 3'b000, 32'h0, 0, 1);

        // Sticky PC and ignored inputs
        step("sticky", 3'b001, 32'h300, 0, 0);
        step("sticky_r1", 3'b010, 32'h10, 0, 0);
        step("sticky_r2", 3'b010, 32'h20, 0, 0);
        step("hold_eret", 3'b000, 32'h0, 0, 1);
        check("hold_eret.valid", 64'(bus.excpt_valid), 64'd1);
        check("hold_eret.cause", 64'(bus.cause), 64'd0);
        step("sticky_ack", 3'b000, 32'h0, 1, 0);
        step("svc_ack", 3'b000, 32'h0, 1, 0);
        check("svc_ack.valid", 64'(bus.excpt_valid), 64'd0);
        check("svc_ack.busy", 64'(bus.busy), 64'd1);
        step("sticky_eret", 3'b000, 32'h0, 0, 1);
        check("sticky.cause", 64'(bus.cause), 64'd1);
        check("sticky.epc", 64'(bus.epc), 64'h10);
        step("sticky_ack2", 3'b000, 32'h0, 1, 0);
        step("sticky_eret2", 3'b000, 32'h0, 0, 1);

        // Async reset mid-HOLD, between edges
        step("rst_hold", 3'b101, 32'h44, 0, 0);
        bus.excpt_req = '0;
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        compare_model("async_rst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        step("post_rst", 3'b000, 32'h0, 0, 0);
        check("post_rst.busy", 64'(bus.busy), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [2:0]  r;
            logic [31:0] p;
            logic        a;
            logic        e;
            r = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            p = $urandom;
            a = ($urandom_range(0, 1) == 1);
            e = ($urandom_range(0, 2) == 0);
            step("rand", r, p, a, e);
        end

        // Parametrised instance: 5 causes, base 0x1000
        step5(5'b10000, 32'h1234, 0, 0);
        bus5.excpt_req = '0;
        check("p5.valid", 64'(bus5.excpt_valid), 64'd1);
        check("p5.vector", 64'(bus5.excpt_vector), 64'h1004);
        check("p5.cause", 64'(bus5.cause), 64'd4);
        check("p5.epc", 64'(bus5.epc), 64'h1234);
        step5(5'b00000, 32'h0, 1, 0);
        check("p5_ack.valid", 64'(bus5.excpt_valid), 64'd0);
        step5(5'b01001, 32'h55, 0, 1);
        check("p5_eret.cause", 64'(bus5.cause), 64'd3);
        check("p5_eret.vector", 64'(bus5.excpt_vector), 64'h1003);
        check("p5_eret.epc", 64'(bus5.epc), 64'h55);
        check("p5_eret.pending", 64'(bus5.pending), 64'b00001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exception_unit.md
# exception_unit

Parametrised exception controller for the multicycle CPU, replacing the fixed three-way exception-vector mux. Captures per-cause exception requests from the datapath, prioritises them, and registers the handler vector address, EPC and cause code. Holds the request for the control unit until acknowledged. Queues exceptions raised while a handler is running and replays them after `eret`.

## Interface
- `NUM_CAUSES`, default 3: number of exception sources. Cause 0 is invalid opcode, 1 is overflow, 2 is divide-by-zero.
- `ADDR_WIDTH`, default 32: width of PC, EPC and vector.
- `VECTOR_BASE`, default 253: vector address for cause 0. Cause i maps to `VECTOR_BASE + i`.
- `CAUSE_WIDTH`, default `max(1, clog2(NUM_CAUSES))`: width of the cause code.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `excpt_req`  in  NUM_CAUSES  per-cause request, sampled every rising edge. Level or pulse.
- `excpt_pc`  in  ADDR_WIDTH  address of the faulting instruction, valid with `excpt_req`.
- `ctrl_ack`  in  1  control unit accepts the presented exception.
- `eret`  in  1  handler finished.
- `excpt_valid`  out  1  exception presented, waiting for ack.
- `excpt_vector`  out  ADDR_WIDTH  handler vector address, zero-extended.
- `epc`  out  ADDR_WIDTH  saved PC of the exception being presented or serviced.
- `cause`  out  CAUSE_WIDTH  index of the exception being presented or serviced.
- `pending`  out  NUM_CAUSES  queued, unserviced causes.
- `busy`  out  1  state is not IDLE.

## Operation
- States: IDLE, HOLD (presenting the exception, waiting for `ctrl_ack`), SERVICE (handler running, waiting for `eret`).
- Priority: the highest cause index wins. Divide-by-zero beats overflow, and overflow beats opcode.
- Per-cause pending bit `pend[i]` and saved PC `pend_pc[i]`. On the first setting of a bit, the PC is stored. The bit is sticky and later requests for the same cause do not overwrite the PC.
- Every edge, `pend_next = pend | excpt_req`. Any bit newly set this edge stores `excpt_pc`.
- IDLE:
  - If `pend_next` is nonzero, select the top cause k.
  - Register `cause=k`, `epc=pc(k)` and `excpt_vector=VECTOR_BASE+k`.
  - Clear bit k and go to HOLD.
  - Other simultaneous causes remain pending.
- HOLD:
  - `excpt_valid=1`. Outputs are stable.
  - On `ctrl_ack=1`, go to SERVICE.
  - New requests only accumulate into pending.
- SERVICE:
  - `excpt_valid=0`. `epc` and `cause` are held for handler reads.
  - On `eret=1`: if `pend_next` is nonzero, select again as in IDLE and go to HOLD. Otherwise go to IDLE.
- Ignored inputs: `ctrl_ack` in IDLE or SERVICE, and `eret` in IDLE or HOLD.
- Request and `eret` on the same edge in SERVICE: the new request takes part in the selection.
- Causes never preempt: no new exception is presented before `eret`.

## Timing
- Reset, asynchronous, active-low:
  - state goes to IDLE.
  - `excpt_valid=0`, `busy=0`.
  - `excpt_vector=0`, `epc=0`, `cause=0`.
  - `pending=0`.
  - All `pend_pc` are cleared.
- Reset mid-HOLD or mid-SERVICE discards everything.
- Latency:
  - A request sampled at edge n gives `excpt_valid=1` with all outputs valid after edge n (registered, 1 cycle).
  - `ctrl_ack` sampled at edge m drops `excpt_valid` after edge m.
  - `eret` with pending work gives `excpt_valid=1` after the same edge.
- All outputs are registered. There are no combinational input-to-output paths.
- `busy` is 1 in HOLD and SERVICE.
- Width rule: the elaboration check requires `VECTOR_BASE + NUM_CAUSES - 1 < 2**ADDR_WIDTH`.

## Structure
- Package `exception_pkg`:
  - the state enum (IDLE, HOLD, SERVICE);
  - cause constants CAUSE_OPCODE=0, CAUSE_OVERFLOW=1 and CAUSE_DIV0=2;
  - the default VECTOR_BASE.
- Sub-module `prio_enc`: parametrised highest-index-wins encoder (`NUM_CAUSES` inputs). Outputs the index and an any-set flag. Used for every selection.

## Test plan
- **Single cause:** `excpt_req=3'b010`, `excpt_pc=0x40` → one cycle later `excpt_valid=1`, `cause=1`, `excpt_vector=254`, `epc=0x40`. `ctrl_ack` → `excpt_valid=0`, `busy=1`. `eret` → IDLE, `busy=0`.
- **Simultaneous causes:** `excpt_req=3'b111`, `pc=0x80` → `cause=2`, vector 255, `pending=3'b011`. Each `eret` then replays: cause 1 (vector 254), then cause 0 (vector 253), all with `epc=0x80`.
- **Nested request:** in SERVICE for cause 0, raise cause 2 with `pc=0x100` → `pending=3'b100`. `eret` → `excpt_valid=1` after that edge, `cause=2`, `epc=0x100`.
- **Sticky PC and ignored inputs:**
  - Raise cause 1 twice in HOLD, with `pc=0x10` then `0x20` → the replayed `epc=0x10`.
  - `eret` in HOLD and `ctrl_ack` in SERVICE cause no state change.
- **Async reset mid-HOLD:** drop `reset` to 0 between edges → all outputs and `pending` are 0 immediately. After release, IDLE.
- **Parametrisation:** `NUM_CAUSES=5`, `VECTOR_BASE=32'h1000`, request cause 4 → `excpt_vector=0x1004`, `cause=3'd4`.
